// File: rtl/fault_pkg.sv
//------------------------------------------------------------------------------
// Module : fault_pkg
// Brief  : Shared channel state encoding and width helpers for the fault monitor.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fault_pkg;

    typedef enum logic [1:0] {
        S_OK       = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_LATCHED  = 2'd2
    } ch_state_t;

    function automatic int cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

    function automatic int count_width(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

    function automatic int id_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fault_channel.sv
//------------------------------------------------------------------------------
// Module : fault_channel
// Brief  : One debounced, sticky fault channel with clear acknowledge.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fault_channel
    import fault_pkg::*;
#(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic fault_in,
    input  logic fault_mask,
    input  logic clear,
    output logic latched,
    output logic latch_event
);

    localparam int CW = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] c_last = CW'(DEBOUNCE - 1);

    ch_state_t       r_state, w_next_state;
    logic [CW-1:0]   r_cnt, w_next_cnt;
    logic            r_latched;
    logic            w_active;

    assign w_active = fault_in & ~fault_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_OK;
            r_cnt     <= '0;
            r_latched <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_latched <= (w_next_state == S_LATCHED);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        case (r_state)
            S_OK: begin
                if (w_active) begin
                    if (DEBOUNCE == 1) begin
                        w_next_state = S_LATCHED;
                    end else begin
                        w_next_state = S_DEBOUNCE;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            S_DEBOUNCE: begin
                if (!w_active) begin
                    w_next_state = S_OK;
                end else if (r_cnt == c_last) begin
                    w_next_state = S_LATCHED;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            S_LATCHED: begin
                // Clear is refused while the fault is still present.
                if (clear && !fault_in) begin
                    w_next_state = S_OK;
                end
            end
            default: w_next_state = S_OK;
        endcase
    end

    assign latched     = r_latched;
    assign latch_event = (r_state != S_LATCHED) && (w_next_state == S_LATCHED);

endmodule

`default_nettype wire

// File: rtl/fault_monitor_mc.sv
//------------------------------------------------------------------------------
// Module : fault_monitor_mc
// Brief  : Multi-channel fault monitor: lights, relay, count and first-fault id.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fault_monitor_mc
    import fault_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CH-1:0]             fault_in,
    input  logic [N_CH-1:0]             fault_mask,
    input  logic                        clear,
    output logic [N_CH-1:0]             light,
    output logic                        relay_driver,
    output logic [count_width(N_CH)-1:0] fault_count,
    output logic                        first_valid,
    output logic [id_width(N_CH)-1:0]   first_id
);

    localparam int CNTW = count_width(N_CH);
    localparam int IDW  = id_width(N_CH);

    logic [N_CH-1:0] w_latched, w_event, w_next;
    logic [CNTW-1:0] w_next_count, r_count;
    logic [IDW-1:0]  w_first_idx, r_first_id;
    logic            r_relay, r_first_valid;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fault_channel #(
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .fault_in    (fault_in[i]),
            .fault_mask  (fault_mask[i]),
            .clear       (clear),
            .latched     (w_latched[i]),
            .latch_event (w_event[i])
        );
    end

    // Mirror of each channel's next latched value so the summary outputs
    // are registers updating on the same edge as the lights.
    assign w_next = w_event | (w_latched & ~({N_CH{clear}} & ~fault_in));

    always_comb begin
        w_next_count = '0;
        w_first_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_next_count = w_next_count + CNTW'(w_next[i]);
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_event[i]) w_first_idx = IDW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_relay       <= 1'b0;
            r_count       <= '0;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
        end else begin
            r_relay <= |w_next;
            r_count <= w_next_count;
            if (!r_first_valid) begin
                if (|w_event) begin
                    r_first_valid <= 1'b1;
                    r_first_id    <= w_first_idx;
                end
            end else if (!(|w_next)) begin
                r_first_valid <= 1'b0;
            end
        end
    end

    assign light        = w_latched;
    assign relay_driver = r_relay;
    assign fault_count  = r_count;
    assign first_valid  = r_first_valid;
    assign first_id     = r_first_id;

endmodule

`default_nettype wire
